llc_port_arbiter: RTL

//  Shares one lower-level-cache/DRAM port between N_REQ upper-level caches (e.g. L1I, L1D, TLB).

---
 rtl/llc_port_arbiter_if.sv | 47 ++++
 rtl/llc_port_arbiter.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/llc_port_arbiter_if.sv
// ============================================================================
// Module : llc_port_arbiter_if
// Brief  : Requester, response and lower-level port bundle for llc_port_arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface llc_port_arbiter_if #(
    parameter int N_REQ     = 2,
    parameter int B         = 64,
    parameter int ADDR_BITS = 64
);
    logic [N_REQ-1:0]           req_valid_in;
    logic [N_REQ-1:0]           req_ready_out;
    logic [N_REQ-1:0]           req_we_in;
    logic [N_REQ*ADDR_BITS-1:0] req_addr_in;
    logic [N_REQ*B*8-1:0]       req_line_in;
    logic [N_REQ-1:0]           resp_valid_out;
    logic [N_REQ-1:0]           resp_ready_in;
    logic [ADDR_BITS-1:0]       resp_addr_out;
    logic [B*8-1:0]             resp_line_out;
    logic                       lc_valid_out;
    logic                       lc_ready_in;
    logic [ADDR_BITS-1:0]       lc_addr_out;
    logic [B*8-1:0]             lc_value_out;
    logic                       we_out;
    logic                       lc_valid_in;
    logic                       lc_ready_out;
    logic [ADDR_BITS-1:0]       lc_addr_in;
    logic [B*8-1:0]             lc_value_in;

    modport slave (
        input  req_valid_in, req_we_in, req_addr_in, req_line_in, resp_ready_in,
        input  lc_ready_in, lc_valid_in, lc_addr_in, lc_value_in,
        output req_ready_out, resp_valid_out, resp_addr_out, resp_line_out,
        output lc_valid_out, lc_addr_out, lc_value_out, we_out, lc_ready_out
    );

    modport master (
        output req_valid_in, req_we_in, req_addr_in, req_line_in, resp_ready_in,
        output lc_ready_in, lc_valid_in, lc_addr_in, lc_value_in,
        input  req_ready_out, resp_valid_out, resp_addr_out, resp_line_out,
        input  lc_valid_out, lc_addr_out, lc_value_out, we_out, lc_ready_out
    );
endinterface

`default_nettype wire

// File: rtl/llc_port_arbiter.sv
// ============================================================================
// Module : llc_port_arbiter
// Brief  : Round-robin sharing of one lower-level line port among N_REQ caches,
//          one transaction in flight. Optional ARB_PERF_CNT_EN adds counters.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module llc_port_arbiter #(
    parameter int N_REQ     = 2,
    parameter int B         = 64,
    parameter int ADDR_BITS = 64
) (
    input  wire logic           clk_in,
    input  wire logic           rst_N_in,
    llc_port_arbiter_if.slave   bus
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [N_REQ*32-1:0] grant_cnt_out,
    output logic [31:0]         stall_cnt_out
`endif
);
    localparam int c_OFF_BITS = $clog2(B);
    localparam int c_PTR_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int c_LINE_W   = B * 8;
    localparam logic [ADDR_BITS-1:0] c_LINE_MASK = {ADDR_BITS{1'b1}} << c_OFF_BITS;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_RESP = 2'd2,
        S_RETURN    = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_PTR_W-1:0]    r_ptr;
    logic [c_PTR_W-1:0]    r_owner;
    logic                  r_we;
    logic [ADDR_BITS-1:0]  r_addr;
    logic [c_LINE_W-1:0]   r_line;

    logic [2*N_REQ-1:0]    w_valid_dbl;
    logic [N_REQ-1:0]      w_valid_rot;
    logic [c_PTR_W:0]      w_scan_idx;
    logic [c_PTR_W-1:0]    w_grant_idx;
    logic                  w_grant_found;
    logic [N_REQ-1:0]      w_grant_oh;
    logic                  w_accept;
    logic                  w_resp_match;

    // Rotate valids so bit 0 is the requester at the pointer; first set bit wins.
    assign w_valid_dbl = {bus.req_valid_in, bus.req_valid_in};
    assign w_valid_rot = N_REQ'(w_valid_dbl >> r_ptr);

    always_comb begin
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        w_scan_idx    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_scan_idx = {1'b0, r_ptr} + (c_PTR_W+1)'(k);
            if (w_scan_idx >= (c_PTR_W+1)'(N_REQ)) begin
                w_scan_idx = w_scan_idx - (c_PTR_W+1)'(N_REQ);
            end
            if (!w_grant_found && w_valid_rot[k]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = w_scan_idx[c_PTR_W-1:0];
            end
        end
    end

    assign w_grant_oh   = w_grant_found ? (N_REQ'(1) << w_grant_idx) : '0;
    assign w_accept     = (r_state == S_IDLE) && w_grant_found;
    assign w_resp_match = bus.lc_valid_in &&
                          ((bus.lc_addr_in & c_LINE_MASK) == r_addr);

    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:      if (w_accept) w_state_nxt = S_ISSUE;
            S_ISSUE:     if (bus.lc_ready_in) w_state_nxt = r_we ? S_IDLE : S_WAIT_RESP;
            S_WAIT_RESP: if (w_resp_match) w_state_nxt = S_RETURN;
            S_RETURN:    if (bus.resp_ready_in[r_owner]) w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    // r_line holds write data until issue, then is reused for the returned line.
    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            r_ptr   <= '0;
            r_owner <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_line  <= '0;
        end else begin
            if (w_accept) begin
                r_owner <= w_grant_idx;
                r_we    <= bus.req_we_in[w_grant_idx];
                r_addr  <= bus.req_addr_in[int'(w_grant_idx)*ADDR_BITS +: ADDR_BITS] & c_LINE_MASK;
                r_line  <= bus.req_line_in[int'(w_grant_idx)*c_LINE_W +: c_LINE_W];
                r_ptr   <= (w_grant_idx == c_PTR_W'(N_REQ-1)) ? '0 : w_grant_idx + 1'b1;
            end
            if ((r_state == S_WAIT_RESP) && w_resp_match) begin
                r_line <= bus.lc_value_in;
            end
        end
    end

    // Gating ready with reset keeps every output low while reset is asserted.
    assign bus.req_ready_out  = ((r_state == S_IDLE) && rst_N_in) ? w_grant_oh : '0;
    assign bus.lc_valid_out   = (r_state == S_ISSUE);
    assign bus.we_out         = (r_state == S_ISSUE) && r_we;
    assign bus.lc_addr_out    = (r_state == S_ISSUE) ? r_addr : '0;
    assign bus.lc_value_out   = ((r_state == S_ISSUE) && r_we) ? r_line : '0;
    assign bus.lc_ready_out   = (r_state == S_WAIT_RESP);
    assign bus.resp_valid_out = (r_state == S_RETURN) ? (N_REQ'(1) << r_owner) : '0;
    assign bus.resp_addr_out  = (r_state == S_RETURN) ? r_addr : '0;
    assign bus.resp_line_out  = (r_state == S_RETURN) ? r_line : '0;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] r_stall_cnt;

    for (genvar g = 0; g < N_REQ; g++) begin : g_grant_cnt
        logic [31:0] r_cnt;
        always_ff @(posedge clk_in or negedge rst_N_in) begin
            if (!rst_N_in) begin
                r_cnt <= '0;
            end else if (w_accept && (w_grant_idx == c_PTR_W'(g)) && (r_cnt != '1)) begin
                r_cnt <= r_cnt + 32'd1;
            end
        end
        assign grant_cnt_out[g*32 +: 32] = r_cnt;
    end

    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            r_stall_cnt <= '0;
        end else if ((r_state == S_ISSUE) && !bus.lc_ready_in && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end
    assign stall_cnt_out = r_stall_cnt;
`endif

endmodule

`default_nettype wire
